// File: rtl/tl_line_master.sv
// tl_line_master: TileLink-UH initiator for one cache line per command.
// A read becomes a single-beat Get; a write becomes a multi-beat PutFullData.
// The channel-D reply is collected into rsp_rdata with denied/error status.
// Only one transaction is outstanding at a time.
module tl_line_master #(
  parameter int LINE_W    = 256,
  parameter int LINE_LOG2 = 5,
  parameter int SOURCE_ID = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [31:0]       cmd_addr,
  input  logic [LINE_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [LINE_W-1:0] rsp_rdata,
  output logic              rsp_denied,
  output logic              rsp_err,
  output logic [2:0]        tlmst_a_opcode,
  output logic [2:0]        tlmst_a_param,
  output logic [7:0]        tlmst_a_size,
  output logic [2:0]        tlmst_a_source,
  output logic [31:0]       tlmst_a_address,
  output logic [15:0]       tlmst_a_mask,
  output logic [127:0]      tlmst_a_data,
  output logic              tlmst_a_corrupt,
  output logic              tlmst_a_valid,
  input  logic              tlmst_a_ready,
  input  logic [2:0]        tlmst_d_opcode,
  input  logic [1:0]        tlmst_d_param,
  input  logic [7:0]        tlmst_d_size,
  input  logic [2:0]        tlmst_d_sink,
  input  logic [2:0]        tlmst_d_source,
  input  logic              tlmst_d_denied,
  input  logic [127:0]      tlmst_d_data,
  input  logic              tlmst_d_corrupt,
  input  logic              tlmst_d_valid,
  output logic              tlmst_d_ready
);

  // state     | meaning
  // S_IDLE    | waiting for a command, cmd_ready high
  // S_A_PUT   | sending PutFullData beats on channel A
  // S_A_GET   | sending the single Get beat on channel A
  // S_D_WAIT  | accepting channel-D beats
  // S_RSP     | holding the response until rsp_ready

  localparam int BEATS = LINE_W / 128;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
  localparam logic [31:0]   ALIGN_MASK = (32'd1 << LINE_LOG2) - 32'd1;
  localparam logic [2:0]    SRC        = 3'(SOURCE_ID);

  typedef enum logic [2:0] {S_IDLE, S_A_PUT, S_A_GET, S_D_WAIT, S_RSP} state_t;

  state_t            state;
  logic              wr_q;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rdata_q;
  logic [BW-1:0]     beat_q;
  logic              denied_q;
  logic              err_q;
  logic              a_valid_q;
  logic              d_ready_q;
  logic              rsp_valid_q;
  logic              cmd_ready_q;
  logic [2:0]        d_exp_opcode;

  // D fields that carry no meaning for this initiator
  logic unused_d;
  assign unused_d = ^{tlmst_d_param, tlmst_d_size, tlmst_d_sink};

  // AccessAck for a Put, AccessAckData for a Get
  assign d_exp_opcode = wr_q ? 3'd0 : 3'd1;

  // Sequencer: command latch, A beats, D collection, response hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      beat_q      <= '0;
      denied_q    <= 1'b0;
      err_q       <= 1'b0;
      a_valid_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            wr_q        <= cmd_wr;
            addr_q      <= cmd_addr & ~ALIGN_MASK;
            wdata_q     <= cmd_wr ? cmd_wdata : '0;
            rdata_q     <= '0;
            denied_q    <= 1'b0;
            err_q       <= 1'b0;
            beat_q      <= '0;
            cmd_ready_q <= 1'b0;
            a_valid_q   <= 1'b1;
            state       <= cmd_wr ? S_A_PUT : S_A_GET;
          end
        end
        S_A_PUT: begin
          if (tlmst_a_ready) begin
            if (beat_q == LAST_BEAT) begin
              beat_q    <= '0;
              a_valid_q <= 1'b0;
              d_ready_q <= 1'b1;
              state     <= S_D_WAIT;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        S_A_GET: begin
          if (tlmst_a_ready) begin
            a_valid_q <= 1'b0;
            d_ready_q <= 1'b1;
            state     <= S_D_WAIT;
          end
        end
        S_D_WAIT: begin
          if (tlmst_d_valid) begin
            denied_q <= denied_q | tlmst_d_denied;
            err_q    <= err_q | tlmst_d_corrupt | (tlmst_d_opcode != d_exp_opcode)
                        | (tlmst_d_source != SRC);
            if (!wr_q) rdata_q[beat_q*128 +: 128] <= tlmst_d_data;
            if (wr_q || (beat_q == LAST_BEAT)) begin
              beat_q      <= '0;
              d_ready_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              state       <= S_RSP;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rdata_q;
  assign rsp_denied      = denied_q;
  assign rsp_err         = err_q;
  assign tlmst_a_opcode  = wr_q ? 3'd0 : 3'd4;
  assign tlmst_a_param   = 3'd0;
  assign tlmst_a_size    = 8'(LINE_LOG2);
  assign tlmst_a_source  = SRC;
  assign tlmst_a_address = addr_q;
  assign tlmst_a_mask    = 16'hFFFF;
  assign tlmst_a_data    = wdata_q[beat_q*128 +: 128];
  assign tlmst_a_corrupt = 1'b0;
  assign tlmst_a_valid   = a_valid_q;
  assign tlmst_d_ready   = d_ready_q;

endmodule

// File: tb/tb_tl_line_master.sv
// Directed bench for tl_line_master: the bench plays the memory responder,
// keeps its own line store and derives every expected A beat and response.
module tb_tl_line_master;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [31:0]  cmd_addr = '0;
  logic [255:0] cmd_wdata = '0;
  logic         rsp_valid, rsp_ready = 1'b0;
  logic [255:0] rsp_rdata;
  logic         rsp_denied, rsp_err;
  logic [2:0]   a_opcode, a_param, a_source;
  logic [7:0]   a_size;
  logic [31:0]  a_address;
  logic [15:0]  a_mask;
  logic [127:0] a_data;
  logic         a_corrupt, a_valid, a_ready = 1'b0;
  logic [2:0]   d_opcode = '0, d_sink = '0, d_source = '0;
  logic [1:0]   d_param = '0;
  logic [7:0]   d_size = '0;
  logic         d_denied = 1'b0, d_corrupt = 1'b0, d_valid = 1'b0, d_ready;
  logic [127:0] d_data = '0;

  int n_pass = 0;
  int n_total = 0;
  logic [255:0] mem [logic [31:0]];
  logic [255:0] last_rdata;
  logic         last_denied, last_err;
  logic [31:0]  obs_addr;

  always #5 clk = ~clk;

  tl_line_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_denied(rsp_denied), .rsp_err(rsp_err),
    .tlmst_a_opcode(a_opcode), .tlmst_a_param(a_param), .tlmst_a_size(a_size),
    .tlmst_a_source(a_source), .tlmst_a_address(a_address), .tlmst_a_mask(a_mask),
    .tlmst_a_data(a_data), .tlmst_a_corrupt(a_corrupt), .tlmst_a_valid(a_valid),
    .tlmst_a_ready(a_ready),
    .tlmst_d_opcode(d_opcode), .tlmst_d_param(d_param), .tlmst_d_size(d_size),
    .tlmst_d_sink(d_sink), .tlmst_d_source(d_source), .tlmst_d_denied(d_denied),
    .tlmst_d_data(d_data), .tlmst_d_corrupt(d_corrupt), .tlmst_d_valid(d_valid),
    .tlmst_d_ready(d_ready)
  );

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // One full line transaction with the bench acting as responder.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [255:0] wdata,
                        input int a_stall, input logic [1:0] den_mask, input logic bad_src,
                        input logic bad_op, input logic corrupt, input int rsp_stall);
    logic [31:0]  ea;
    logic [255:0] line;
    logic [255:0] exp_rdata;
    logic         exp_den, exp_err, pend, seen, done;
    int nA, nD, ab, dk, t, stall;
    ea        = addr & 32'hFFFF_FFE0;
    line      = mem.exists(ea) ? mem[ea] : '0;
    exp_rdata = wr ? '0 : line;
    nA        = wr ? 2 : 1;
    nD        = wr ? 1 : 2;
    exp_den   = wr ? den_mask[0] : |den_mask;
    exp_err   = bad_src | bad_op | corrupt;

    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!cmd_ready) chk("cmd_ready_timeout", {255'd0, cmd_ready}, 256'd1);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_wdata = '0; cmd_addr = '0;

    ab = 0; pend = 0; seen = 0; t = 0; stall = a_stall;
    while (ab < nA && t < 200) begin
      if (pend) begin
        ab++; pend = 0; a_ready = 1'b0;
        if (ab == nA) break;
      end
      chk("cmd_ready_busy_a", {255'd0, cmd_ready}, 256'd0);
      if (a_valid) begin
        seen = 1;
        if (ab == 0) obs_addr = a_address;
        chk("a_beat", {62'd0, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt, a_data},
            {62'd0, (wr ? 3'd0 : 3'd4), 3'd0, 8'd5, 3'd0, ea, 16'hFFFF, 1'b0,
             (wr ? wdata[ab*128 +: 128] : 128'd0)});
        if (stall > 0) begin a_ready = 1'b0; stall--; end
        else begin a_ready = 1'b1; pend = 1; end
      end else begin
        a_ready = 1'b0;
        if (seen) chk("a_valid_drop", 256'd0, 256'd1);
      end
      @(negedge clk); t++;
    end
    a_ready = 1'b0;
    if (ab < nA) chk("a_timeout", ab, nA);

    dk = 0; pend = 0; t = 0;
    while (dk < nD && t < 200) begin
      if (pend) begin
        dk++; pend = 0; d_valid = 1'b0;
        if (dk == nD) break;
      end
      chk("cmd_ready_busy_d", {255'd0, cmd_ready}, 256'd0);
      if (d_ready) begin
        d_valid   = 1'b1;
        d_opcode  = bad_op ? 3'd2 : (wr ? 3'd0 : 3'd1);
        d_source  = bad_src ? 3'd5 : 3'd0;
        d_denied  = den_mask[dk];
        d_corrupt = corrupt;
        d_param   = 2'd3; d_size = 8'd5; d_sink = 3'd7;
        d_data    = wr ? 128'd0 : line[dk*128 +: 128];
        pend      = 1;
      end else d_valid = 1'b0;
      @(negedge clk); t++;
    end
    d_valid = 1'b0; d_denied = 1'b0; d_corrupt = 1'b0;
    if (dk < nD) chk("d_timeout", dk, nD);

    t = 0; stall = rsp_stall; done = 0;
    while (!done && t < 100) begin
      if (rsp_valid) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_status", {254'd0, rsp_denied, rsp_err}, {254'd0, exp_den, exp_err});
        chk("cmd_ready_busy_rsp", {255'd0, cmd_ready}, 256'd0);
        last_rdata = rsp_rdata; last_denied = rsp_denied; last_err = rsp_err;
        if (stall > 0) begin rsp_ready = 1'b0; stall--; end
        else begin rsp_ready = 1'b1; done = 1; end
      end else rsp_ready = 1'b0;
      @(negedge clk); t++;
    end
    rsp_ready = 1'b0;
    if (!done) chk("rsp_timeout", 256'd0, 256'd1);
    chk("post_rsp", {254'd0, rsp_valid, cmd_ready}, 256'd1);
    if (wr) mem[ea] = wdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    chk("reset_outs", {251'd0, cmd_ready, a_valid, d_ready, rsp_valid, rsp_err}, 256'd0);
    chk("reset_rdata", rsp_rdata, 256'd0);
    @(negedge clk); rst = 1'b1;

    // 1: two-beat write to 0x20
    do_txn(1'b1, 32'h20, {128'd2, 128'd1}, 0, 2'b00, 1'b0, 1'b0, 1'b0, 0);
    chk("t1_err_lit", {255'd0, last_err}, 256'd0);

    // 2: read back
    do_txn(1'b0, 32'h20, '0, 0, 2'b00, 1'b0, 1'b0, 1'b0, 0);
    chk("t2_rdata_lit", last_rdata, {128'd2, 128'd1});

    // 3: unaligned address and A backpressure
    do_txn(1'b1, 32'h2F, {128'hCAFE_F00D_0000_0000_0000_0000_DEAD_BEEF, 128'h1234_5678}, 5,
           2'b00, 1'b0, 1'b0, 1'b0, 0);
    chk("t3_addr_lit", {224'd0, obs_addr}, {224'd0, 32'h20});
    do_txn(1'b0, 32'h20, '0, 2, 2'b00, 1'b0, 1'b0, 1'b0, 0);
    chk("t3_rdata_lit", last_rdata[127:0], 256'h1234_5678);

    // 4: denied on second read beat, then source mismatch, then bad opcode on a write
    do_txn(1'b0, 32'h20, '0, 0, 2'b10, 1'b0, 1'b0, 1'b0, 0);
    chk("t4_denied_lit", {254'd0, last_denied, last_err}, 256'd2);
    do_txn(1'b0, 32'h20, '0, 0, 2'b00, 1'b1, 1'b0, 1'b0, 0);
    chk("t4_src_lit", {255'd0, last_err}, 256'd1);
    do_txn(1'b1, 32'h60, {128'd7, 128'd6}, 0, 2'b00, 1'b0, 1'b1, 1'b0, 0);
    chk("t4_op_lit", {255'd0, last_err}, 256'd1);
    do_txn(1'b0, 32'h60, '0, 0, 2'b00, 1'b0, 1'b0, 1'b1, 0);
    chk("t4_corrupt_lit", {255'd0, last_err}, 256'd1);

    // 5: reset between write beats aborts the burst
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h40; cmd_wdata = {128'd9, 128'd8};
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t5_a_valid_b0", {255'd0, a_valid}, 256'd1);
    a_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0;
    chk("t5_a_beat1", {128'd0, a_data}, 256'd9);
    rst = 1'b0;
    #1;
    chk("t5_in_reset", {254'd0, a_valid, cmd_ready}, 256'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("t5_ready_after", {255'd0, cmd_ready}, 256'd1);
    do_txn(1'b0, 32'h40, '0, 0, 2'b00, 1'b0, 1'b0, 1'b0, 0);
    chk("t5_read_lit", last_rdata, 256'd0);

    // 6: response backpressure
    do_txn(1'b0, 32'h20, '0, 0, 2'b00, 1'b0, 1'b0, 1'b0, 10);
    chk("t6_rdata_lit", last_rdata[255:128], 256'hCAFE_F00D_0000_0000_0000_0000_DEAD_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
